stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_pkg.sv | 32 +++
 rtl/instr_counter.sv | 18 +
 rtl/stage_sequencer.sv | 103 ++++++++++
 tb/tb_stage_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stage_pkg.sv
// Shared stage encodings and sequencer state type for the stage sequencer
// and the stage-enable decoder.
package stage_pkg;

   localparam int COUNT_WIDTH_DEFAULT = 16;

   localparam logic [2:0] STAGE_IDLE      = 3'd0;
   localparam logic [2:0] STAGE_FETCH     = 3'd1;
   localparam logic [2:0] STAGE_DECODE    = 3'd2;
   localparam logic [2:0] STAGE_EXECUTE   = 3'd3;
   localparam logic [2:0] STAGE_MEMORY    = 3'd4;
   localparam logic [2:0] STAGE_WRITEBACK = 3'd5;

   // PRIME shares the Write Back stage code but is a separate state so it never retires.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_S1,
      ST_S2,
      ST_S3,
      ST_S4,
      ST_S5
   } seq_state_t;

   // One-hot stage enables, bit 0 = Idle .. bit 5 = Write Back.
   function automatic logic [5:0] stage_enable(input logic [2:0] stage);
      logic [5:0] en;
      en = 6'd1 << stage;
      return en;
   endfunction

endpackage

// File: rtl/instr_counter.sv
// Wrapping retired-instruction counter with enable and synchronous clear.
module instr_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (enable)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer with a start-up priming pass, stall,
// single-step and halt-at-boundary control.
module stage_sequencer
   import stage_pkg::*;
#(
   parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   Run,
   input  logic                   Halt,
   input  logic                   Stall,
   input  logic                   StepMode,
   input  logic                   Step,
   output logic [2:0]             Stage,
   output logic                   Priming,
   output logic                   Busy,
   output logic                   InstrDone,
   output logic [COUNT_WIDTH-1:0] InstrCount
);

   seq_state_t state;
   logic       halt_pending;
   logic       adv;
   logic       retire;

   assign adv    = !Stall && (!StepMode || Step);
   assign retire = adv && (state == ST_S5);
   assign Busy   = (Stage != STAGE_IDLE);

   // Halt is latched even on stalled cycles; the later clear on entry to IDLE wins.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= ST_IDLE;
         Stage        <= STAGE_IDLE;
         Priming      <= 1'b0;
         InstrDone    <= 1'b0;
         halt_pending <= 1'b0;
      end else begin
         InstrDone <= 1'b0;
         if (state != ST_IDLE && Halt)
            halt_pending <= 1'b1;
         if (adv) begin
            case (state)
               ST_IDLE: begin
                  if (Run && !Halt) begin
                     state   <= ST_PRIME;
                     Stage   <= STAGE_WRITEBACK;
                     Priming <= 1'b1;
                  end
               end
               ST_PRIME: begin
                  state   <= ST_S1;
                  Stage   <= STAGE_FETCH;
                  Priming <= 1'b0;
               end
               ST_S1: begin
                  state <= ST_S2;
                  Stage <= STAGE_DECODE;
               end
               ST_S2: begin
                  state <= ST_S3;
                  Stage <= STAGE_EXECUTE;
               end
               ST_S3: begin
                  state <= ST_S4;
                  Stage <= STAGE_MEMORY;
               end
               ST_S4: begin
                  state <= ST_S5;
                  Stage <= STAGE_WRITEBACK;
               end
               ST_S5: begin
                  InstrDone <= 1'b1;
                  if (halt_pending || !Run) begin
                     state        <= ST_IDLE;
                     Stage        <= STAGE_IDLE;
                     halt_pending <= 1'b0;
                  end else begin
                     state <= ST_S1;
                     Stage <= STAGE_FETCH;
                  end
               end
               default: begin
                  state   <= ST_IDLE;
                  Stage   <= STAGE_IDLE;
                  Priming <= 1'b0;
               end
            endcase
         end
      end
   end

   instr_counter #(
      .WIDTH (COUNT_WIDTH)
   ) u_instr_counter (
      .clk    (Clock),
      .clear  (Reset),
      .enable (retire),
      .count  (InstrCount)
   );

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer with a 4-bit counter so
// the wrap-around can be reached quickly.
module tb_stage_sequencer;

   logic       Clock;
   logic       Reset;
   logic       Run;
   logic       Halt;
   logic       Stall;
   logic       StepMode;
   logic       Step;
   logic [2:0] Stage;
   logic       Priming;
   logic       Busy;
   logic       InstrDone;
   logic [3:0] InstrCount;

   int checkCount;
   int errorCount;

   stage_sequencer #(
      .COUNT_WIDTH (4)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Run        (Run),
      .Halt       (Halt),
      .Stall      (Stall),
      .StepMode   (StepMode),
      .Step       (Step),
      .Stage      (Stage),
      .Priming    (Priming),
      .Busy       (Busy),
      .InstrDone  (InstrDone),
      .InstrCount (InstrCount)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic run, input logic halt, input logic stall,
                                input logic stepMode, input logic step);
      Run      = run;
      Halt     = halt;
      Stall    = stall;
      StepMode = stepMode;
      Step     = step;
   endtask

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic tickExpect(input string tag, input logic [2:0] expStage, input logic expPriming);
      tick();
      checkOutput({tag, ".stage"}, Stage, expStage);
      checkOutput({tag, ".priming"}, Priming, expPriming);
   endtask

   int seqStage[7]   = '{5, 1, 2, 3, 4, 5, 1};
   int seqPriming[7] = '{1, 0, 0, 0, 0, 0, 0};
   int seqDone[7]    = '{0, 0, 0, 0, 0, 0, 1};

   initial begin
      checkCount = 0;
      errorCount = 0;
      Reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      tick();
      checkOutput("rst.stage", Stage, 0);
      checkOutput("rst.priming", Priming, 0);
      checkOutput("rst.busy", Busy, 0);
      checkOutput("rst.done", InstrDone, 0);
      checkOutput("rst.count", InstrCount, 0);

      Reset = 1'b0;
      tickExpect("idle_norun", 0, 0);

      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         tick();
         checkOutput($sformatf("run.stage%0d", i), Stage, seqStage[i]);
         checkOutput($sformatf("run.priming%0d", i), Priming, seqPriming[i]);
         checkOutput($sformatf("run.done%0d", i), InstrDone, seqDone[i]);
      end
      checkOutput("run.count", InstrCount, 1);
      checkOutput("run.busy", Busy, 1);

      tickExpect("pre_stall", 2, 0);
      tickExpect("pre_stall", 3, 0);
      applyStimulus(1, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++)
         tickExpect($sformatf("stall%0d", i), 3, 0);
      checkOutput("stall.count", InstrCount, 1);
      applyStimulus(1, 0, 0, 0, 0);
      tickExpect("post_stall", 4, 0);
      tickExpect("post_stall", 5, 0);
      tickExpect("post_stall", 1, 0);
      checkOutput("post_stall.done", InstrDone, 1);
      checkOutput("post_stall.count", InstrCount, 2);

      tickExpect("halt", 2, 0);
      applyStimulus(1, 1, 0, 0, 0);
      tickExpect("halt", 3, 0);
      applyStimulus(1, 0, 0, 0, 0);
      tickExpect("halt", 4, 0);
      tickExpect("halt", 5, 0);
      tickExpect("halt.idle", 0, 0);
      checkOutput("halt.done", InstrDone, 1);
      checkOutput("halt.count", InstrCount, 3);
      checkOutput("halt.busy", Busy, 0);
      tickExpect("restart", 5, 1);
      checkOutput("restart.done", InstrDone, 0);
      tickExpect("restart", 1, 0);

      applyStimulus(0, 0, 0, 0, 0);
      tickExpect("runoff", 2, 0);
      tickExpect("runoff", 3, 0);
      tickExpect("runoff", 4, 0);
      tickExpect("runoff", 5, 0);
      tickExpect("runoff.idle", 0, 0);
      checkOutput("runoff.count", InstrCount, 4);
      tickExpect("runoff.stay", 0, 0);

      applyStimulus(1, 1, 0, 0, 0);
      tickExpect("halt_wins", 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      tickExpect("prime_halt", 5, 1);
      applyStimulus(1, 1, 0, 0, 0);
      tickExpect("prime_halt", 1, 0);
      applyStimulus(1, 0, 0, 0, 0);
      tickExpect("prime_halt", 2, 0);
      tickExpect("prime_halt", 3, 0);
      tickExpect("prime_halt", 4, 0);
      tickExpect("prime_halt", 5, 0);
      tickExpect("prime_halt.idle", 0, 0);
      checkOutput("prime_halt.count", InstrCount, 5);

      applyStimulus(1, 0, 0, 1, 0);
      tickExpect("step.wait", 0, 0);
      applyStimulus(1, 0, 0, 1, 1);
      tickExpect("step.p1", 5, 1);
      applyStimulus(1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++)
         tickExpect("step.hold1", 5, 1);
      applyStimulus(1, 0, 0, 1, 1);
      tickExpect("step.p2", 1, 0);
      applyStimulus(1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++)
         tickExpect("step.hold2", 1, 0);
      applyStimulus(1, 0, 1, 1, 1);
      tickExpect("step.stalled", 1, 0);
      applyStimulus(1, 0, 0, 1, 0);
      tickExpect("step.lost", 1, 0);
      tickExpect("step.lost", 1, 0);
      applyStimulus(1, 0, 0, 1, 1);
      tickExpect("step.p3", 2, 0);
      applyStimulus(1, 0, 0, 0, 0);
      tickExpect("free", 3, 0);
      tickExpect("free", 4, 0);
      tickExpect("free", 5, 0);
      tickExpect("free", 1, 0);
      checkOutput("free.count", InstrCount, 6);

      tickExpect("to7", 2, 0);
      tickExpect("to7", 3, 0);
      tickExpect("to7", 4, 0);
      tickExpect("to7", 5, 0);
      tickExpect("to7", 1, 0);
      checkOutput("to7.count", InstrCount, 7);
      tickExpect("to7", 2, 0);
      applyStimulus(1, 1, 0, 0, 0);
      tickExpect("to7", 3, 0);
      applyStimulus(1, 0, 0, 0, 0);
      tickExpect("to7", 4, 0);
      checkOutput("pre_reset.count", InstrCount, 7);
      Reset = 1'b1;
      tickExpect("midreset", 0, 0);
      checkOutput("midreset.count", InstrCount, 0);
      checkOutput("midreset.done", InstrDone, 0);
      checkOutput("midreset.busy", Busy, 0);
      Reset = 1'b0;
      tickExpect("after_reset", 5, 1);
      tickExpect("after_reset", 1, 0);
      tickExpect("after_reset", 2, 0);
      tickExpect("after_reset", 3, 0);
      tickExpect("after_reset", 4, 0);
      tickExpect("after_reset", 5, 0);
      tickExpect("after_reset.no_halt", 1, 0);
      checkOutput("after_reset.count", InstrCount, 1);

      for (int n = 0; n < 14; n++)
         for (int k = 0; k < 5; k++)
            tick();
      checkOutput("wrap.stage", Stage, 1);
      checkOutput("wrap.count15", InstrCount, 15);
      for (int k = 0; k < 4; k++)
         tick();
      checkOutput("wrap.s5.stage", Stage, 5);
      checkOutput("wrap.s5.count", InstrCount, 15);
      tick();
      checkOutput("wrap.count0", InstrCount, 0);
      checkOutput("wrap.done", InstrDone, 1);
      checkOutput("wrap.stage1", Stage, 1);
      tick();
      checkOutput("wrap.hold0", InstrCount, 0);
      checkOutput("wrap.done_low", InstrDone, 0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
